// File: rtl/i2c_slave_pkg.sv
// I2C register-file target: shared types and defaults.
// Holds the controller state encoding and the default bus address.
package i2c_slave_pkg;

  localparam logic [6:0] DEV_ADDR_DEFAULT = 7'h1A;

  typedef enum logic [3:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    PTR,
    PTR_ACK,
    WR_DATA,
    WR_ACK,
    RD_DATA,
    RD_ACK
  } state_e;

endpackage

// File: rtl/i2c_line_sync.sv
// I2C pad conditioning: 2-flop synchronizers plus registered
// SCL edge and START/STOP detection on the synchronized lines.
module i2c_line_sync (
  input  logic clk,
  input  logic reset,
  input  logic scl_i,
  input  logic sda_i,
  output logic scl,
  output logic sda,
  output logic scl_rise,
  output logic scl_fall,
  output logic start,
  output logic stop
);

  // [0] meta, [1] sync, [2] previous sync value
  logic [2:0] scl_pipe_q, scl_pipe_d;
  logic [2:0] sda_pipe_q, sda_pipe_d;
  // {stop, start, fall, rise}
  logic [3:0] evt_q, evt_d;

  // shift the pads in and detect edges/conditions on synced values
  always_comb begin
    scl_pipe_d = {scl_pipe_q[1:0], scl_i};
    sda_pipe_d = {sda_pipe_q[1:0], sda_i};
    evt_d[0] = scl_pipe_q[1] & ~scl_pipe_q[2];
    evt_d[1] = ~scl_pipe_q[1] & scl_pipe_q[2];
    evt_d[2] = scl_pipe_q[1] & scl_pipe_q[2]
             & ~sda_pipe_q[1] & sda_pipe_q[2];
    evt_d[3] = scl_pipe_q[1] & scl_pipe_q[2]
             & sda_pipe_q[1] & ~sda_pipe_q[2];
  end

  // idle bus is high, so resetting to 1 avoids a false START
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scl_pipe_q <= '1;
      sda_pipe_q <= '1;
      evt_q      <= '0;
    end else begin
      scl_pipe_q <= scl_pipe_d;
      sda_pipe_q <= sda_pipe_d;
      evt_q      <= evt_d;
    end
  end

  assign scl      = scl_pipe_q[2];
  assign sda      = sda_pipe_q[2];
  assign scl_rise = evt_q[0];
  assign scl_fall = evt_q[1];
  assign start    = evt_q[2];
  assign stop     = evt_q[3];

endmodule

// File: rtl/i2c_slave_regfile.sv
// I2C target with an auto-incrementing pointer into a flop
// register file; write pointer, then write or read bytes.
module i2c_slave_regfile
  import i2c_slave_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR = DEV_ADDR_DEFAULT,
  parameter int         NUM_REGS = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i2c_scl_i,
  input  logic       i2c_sda_i,
  output logic       i2c_sda_o,
  output logic       i2c_sda_t,
  output logic       reg_wr_strobe,
  output logic [7:0] reg_wr_addr,
  output logic [7:0] reg_wr_data,
  output logic       bus_active
);

  localparam int PW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  logic scl, sda, scl_rise, scl_fall, start, stop;

  i2c_line_sync u_sync (
    .clk      (clk),
    .reset    (reset),
    .scl_i    (i2c_scl_i),
    .sda_i    (i2c_sda_i),
    .scl      (scl),
    .sda      (sda),
    .scl_rise (scl_rise),
    .scl_fall (scl_fall),
    .start    (start),
    .stop     (stop)
  );

  state_e          state_q, state_d;
  logic [3:0]      bit_cnt_q, bit_cnt_d;
  logic [7:0]      shreg_q, shreg_d;
  logic            phase_q, phase_d;
  logic            rw_q, rw_d;
  logic [PW-1:0]   ptr_q, ptr_d;
  logic            sda_t_q, sda_t_d;
  logic            strobe_q, strobe_d;
  logic [7:0]      wr_addr_q, wr_addr_d;
  logic [7:0]      wr_data_q, wr_data_d;
  logic            active_q, active_d;
  logic [7:0]      regs_q [NUM_REGS];
  logic [7:0]      regs_d [NUM_REGS];

  logic          sample;
  logic [7:0]    rx_byte;
  logic          ptr_ok;
  logic [PW-1:0] ptr_inc;
  logic [7:0]    rd_byte;

  // receive path and pointer helpers
  always_comb begin
    sample  = scl_rise & scl;
    rx_byte = {shreg_q[6:0], sda};
    ptr_ok  = {1'b0, rx_byte} < 9'(NUM_REGS);
    ptr_inc = (ptr_q == PW'(NUM_REGS - 1))
            ? '0 : ptr_q + 1'b1;
    rd_byte = regs_q[ptr_q];
  end

  // protocol state machine next-state and output logic
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shreg_d   = shreg_q;
    phase_d   = phase_q;
    rw_d      = rw_q;
    ptr_d     = ptr_q;
    sda_t_d   = sda_t_q;
    strobe_d  = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    active_d  = active_q;
    regs_d    = regs_q;

    if (start) begin
      state_d   = ADDR;
      bit_cnt_d = '0;
      phase_d   = 1'b0;
      sda_t_d   = 1'b1;
      active_d  = 1'b1;
    end else if (stop) begin
      state_d  = IDLE;
      phase_d  = 1'b0;
      sda_t_d  = 1'b1;
      active_d = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: ;
        ADDR, PTR, WR_DATA: begin
          if (sample) begin
            shreg_d   = rx_byte;
            bit_cnt_d = bit_cnt_q + 1'b1;
            if (bit_cnt_q == 4'd7) begin
              bit_cnt_d = '0;
              phase_d   = 1'b0;
              if (state_q == ADDR) begin
                if (rx_byte[7:1] == DEV_ADDR) begin
                  rw_d    = rx_byte[0];
                  state_d = ADDR_ACK;
                end else begin
                  state_d = IDLE;
                end
              end else if (state_q == PTR) begin
                if (ptr_ok) begin
                  ptr_d   = rx_byte[PW-1:0];
                  state_d = PTR_ACK;
                end else begin
                  state_d = IDLE;
                end
              end else begin
                state_d = WR_ACK;
              end
            end
          end
        end
        ADDR_ACK, PTR_ACK, WR_ACK: begin
          if (scl_fall) begin
            if (!phase_q) begin
              sda_t_d = 1'b0;
              phase_d = 1'b1;
            end else begin
              sda_t_d   = 1'b1;
              phase_d   = 1'b0;
              bit_cnt_d = '0;
              if (state_q == ADDR_ACK && rw_q) begin
                shreg_d   = rd_byte;
                sda_t_d   = rd_byte[7];
                bit_cnt_d = 4'd1;
                state_d   = RD_DATA;
              end else if (state_q == ADDR_ACK) begin
                state_d = PTR;
              end else if (state_q == PTR_ACK) begin
                state_d = WR_DATA;
              end else begin
                regs_d[ptr_q] = shreg_q;
                strobe_d      = 1'b1;
                wr_addr_d     = 8'(ptr_q);
                wr_data_d     = shreg_q;
                ptr_d         = ptr_inc;
                state_d       = WR_DATA;
              end
            end
          end
        end
        RD_DATA: begin
          if (scl_fall) begin
            if (bit_cnt_q == 4'd8) begin
              sda_t_d = 1'b1;
              phase_d = 1'b0;
              state_d = RD_ACK;
            end else begin
              shreg_d   = {shreg_q[6:0], 1'b0};
              sda_t_d   = shreg_q[6];
              bit_cnt_d = bit_cnt_q + 1'b1;
            end
          end
        end
        RD_ACK: begin
          if (!phase_q) begin
            if (sample) begin
              if (sda) begin
                state_d = IDLE;
              end else begin
                phase_d = 1'b1;
                ptr_d   = ptr_inc;
              end
            end
          end else if (scl_fall) begin
            phase_d   = 1'b0;
            shreg_d   = rd_byte;
            sda_t_d   = rd_byte[7];
            bit_cnt_d = 4'd1;
            state_d   = RD_DATA;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // state, registered outputs and register file
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      shreg_q   <= '0;
      phase_q   <= 1'b0;
      rw_q      <= 1'b0;
      ptr_q     <= '0;
      sda_t_q   <= 1'b1;
      strobe_q  <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      active_q  <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shreg_q   <= shreg_d;
      phase_q   <= phase_d;
      rw_q      <= rw_d;
      ptr_q     <= ptr_d;
      sda_t_q   <= sda_t_d;
      strobe_q  <= strobe_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      active_q  <= active_d;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= regs_d[i];
    end
  end

  assign i2c_sda_o     = 1'b0;
  assign i2c_sda_t     = sda_t_q;
  assign reg_wr_strobe = strobe_q;
  assign reg_wr_addr   = wr_addr_q;
  assign reg_wr_data   = wr_data_q;
  assign bus_active    = active_q;

endmodule

// File: tb/tb_i2c_slave_regfile.sv
// Directed bench for i2c_slave_regfile driving a bit-banged
// I2C master with hand-computed expected bytes and ACKs.
`timescale 1ns/1ps
module tb_i2c_slave_regfile;
  import i2c_slave_pkg::*;

  localparam int Q = 200;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       m_scl = 1'b1;
  logic       m_sda = 1'b1;
  logic       i2c_sda_o, i2c_sda_t;
  logic       reg_wr_strobe;
  logic [7:0] reg_wr_addr, reg_wr_data;
  logic       bus_active;
  wire        sda_line = m_sda & (i2c_sda_t | i2c_sda_o);

  int errors = 0;
  int checks = 0;
  int strobe_cnt = 0;
  int sda_low_cnt = 0;
  logic [7:0] last_addr = 8'h00;
  logic [7:0] last_data = 8'h00;

  i2c_slave_regfile #(.DEV_ADDR(7'h1A), .NUM_REGS(16)) dut (
    .clk           (clk),
    .reset         (reset),
    .i2c_scl_i     (m_scl),
    .i2c_sda_i     (sda_line),
    .i2c_sda_o     (i2c_sda_o),
    .i2c_sda_t     (i2c_sda_t),
    .reg_wr_strobe (reg_wr_strobe),
    .reg_wr_addr   (reg_wr_addr),
    .reg_wr_data   (reg_wr_data),
    .bus_active    (bus_active)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (reg_wr_strobe) begin
      strobe_cnt <= strobe_cnt + 1;
      last_addr  <= reg_wr_addr;
      last_data  <= reg_wr_data;
    end
    if (!i2c_sda_t) sda_low_cnt <= sda_low_cnt + 1;
  end

  task automatic i2c_start;
    m_sda = 1'b1; #Q;
    m_scl = 1'b1; #Q;
    m_sda = 1'b0; #Q;
    m_scl = 1'b0; #Q;
  endtask

  task automatic i2c_stop;
    m_sda = 1'b0; #Q;
    m_scl = 1'b1; #Q;
    m_sda = 1'b1; #Q;
  endtask

  task automatic wr_bit(input logic b);
    m_sda = b; #Q;
    m_scl = 1'b1; #(2*Q);
    m_scl = 1'b0; #Q;
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    for (int i = 7; i >= 0; i--) wr_bit(b[i]);
    m_sda = 1'b1; #Q;
    m_scl = 1'b1; #Q;
    ack = sda_line; #Q;
    m_scl = 1'b0; #Q;
  endtask

  task automatic recv_byte(input logic ack_in, output logic [7:0] d);
    for (int i = 7; i >= 0; i--) begin
      m_sda = 1'b1; #Q;
      m_scl = 1'b1; #Q;
      d[i] = sda_line; #Q;
      m_scl = 1'b0; #Q;
    end
    m_sda = ack_in; #Q;
    m_scl = 1'b1; #(2*Q);
    m_scl = 1'b0; #Q;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (5) @(negedge clk);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    checks++; if (i2c_sda_t !== 1'b1) begin errors++;
      $display("FAIL rst_sda_t: got %b expected 1", i2c_sda_t); end
    checks++; if (i2c_sda_o !== 1'b0) begin errors++;
      $display("FAIL rst_sda_o: got %b expected 0", i2c_sda_o); end
    checks++; if (reg_wr_strobe !== 1'b0) begin errors++;
      $display("FAIL rst_strobe: got %b expected 0", reg_wr_strobe); end
    checks++; if (reg_wr_addr !== 8'h00) begin errors++;
      $display("FAIL rst_addr: got %h expected 00", reg_wr_addr); end
    checks++; if (reg_wr_data !== 8'h00) begin errors++;
      $display("FAIL rst_data: got %h expected 00", reg_wr_data); end
    checks++; if (bus_active !== 1'b0) begin errors++;
      $display("FAIL rst_active: got %b expected 0", bus_active); end
    checks++; if (dut.state_q !== IDLE) begin errors++;
      $display("FAIL rst_state: got %0d expected IDLE", dut.state_q); end
  endtask

  task automatic test_write;
    logic a0, a1, a2;
    int base;
    base = strobe_cnt;
    i2c_start;
    send_byte(8'h34, a0);
    send_byte(8'h03, a1);
    checks++; if (bus_active !== 1'b1) begin errors++;
      $display("FAIL wr_active: got %b expected 1", bus_active); end
    send_byte(8'hA5, a2);
    i2c_stop;
    repeat (10) @(negedge clk);
    checks++; if ({a0, a1, a2} !== 3'b000) begin errors++;
      $display("FAIL wr_acks: got %b expected 000", {a0, a1, a2}); end
    checks++; if (strobe_cnt - base !== 1) begin errors++;
      $display("FAIL wr_strobes: got %0d expected 1", strobe_cnt - base); end
    checks++; if (last_addr !== 8'h03 || last_data !== 8'hA5) begin errors++;
      $display("FAIL wr_commit: got %h/%h expected 03/a5", last_addr, last_data); end
    checks++; if (dut.regs_q[3] !== 8'hA5) begin errors++;
      $display("FAIL wr_reg3: got %h expected a5", dut.regs_q[3]); end
    checks++; if (bus_active !== 1'b0) begin errors++;
      $display("FAIL wr_idle: got %b expected 0", bus_active); end
  endtask

  task automatic test_write_reg4;
    logic a0, a1, a2;
    i2c_start;
    send_byte(8'h34, a0);
    send_byte(8'h04, a1);
    send_byte(8'h5C, a2);
    i2c_stop;
    repeat (10) @(negedge clk);
    checks++; if (last_addr !== 8'h04 || last_data !== 8'h5C) begin errors++;
      $display("FAIL wr4_commit: got %h/%h expected 04/5c", last_addr, last_data); end
  endtask

  task automatic test_read;
    logic a0, a1, a2;
    logic [7:0] d0, d1;
    int base;
    base = strobe_cnt;
    i2c_start;
    send_byte(8'h34, a0);
    send_byte(8'h03, a1);
    i2c_start;
    send_byte(8'h35, a2);
    recv_byte(1'b0, d0);
    recv_byte(1'b1, d1);
    repeat (10) @(negedge clk);
    checks++; if ({a0, a1, a2} !== 3'b000) begin errors++;
      $display("FAIL rd_acks: got %b expected 000", {a0, a1, a2}); end
    checks++; if (d0 !== 8'hA5) begin errors++;
      $display("FAIL rd_byte0: got %h expected a5", d0); end
    checks++; if (d1 !== 8'h5C) begin errors++;
      $display("FAIL rd_byte1: got %h expected 5c", d1); end
    checks++; if (dut.state_q !== IDLE) begin errors++;
      $display("FAIL rd_nack_idle: got %0d expected IDLE", dut.state_q); end
    checks++; if (i2c_sda_t !== 1'b1) begin errors++;
      $display("FAIL rd_release: got %b expected 1", i2c_sda_t); end
    i2c_stop;
    repeat (10) @(negedge clk);
    checks++; if (strobe_cnt - base !== 0) begin errors++;
      $display("FAIL rd_strobes: got %0d expected 0", strobe_cnt - base); end
  endtask

  task automatic test_nomatch;
    logic a0, a1;
    int base_s, base_l;
    base_s = strobe_cnt;
    base_l = sda_low_cnt;
    i2c_start;
    send_byte(8'h36, a0);
    send_byte(8'h00, a1);
    repeat (10) @(negedge clk);
    checks++; if ({a0, a1} !== 2'b11) begin errors++;
      $display("FAIL nm_acks: got %b expected 11", {a0, a1}); end
    checks++; if (dut.state_q !== IDLE) begin errors++;
      $display("FAIL nm_state: got %0d expected IDLE", dut.state_q); end
    i2c_stop;
    repeat (10) @(negedge clk);
    checks++; if (sda_low_cnt - base_l !== 0) begin errors++;
      $display("FAIL nm_driven: got %0d expected 0", sda_low_cnt - base_l); end
    checks++; if (strobe_cnt - base_s !== 0) begin errors++;
      $display("FAIL nm_strobes: got %0d expected 0", strobe_cnt - base_s); end
  endtask

  task automatic test_wrap;
    logic a0, a1, a2, a3, a4, a5, a6;
    logic [7:0] d0, d1;
    int base;
    base = strobe_cnt;
    i2c_start;
    send_byte(8'h34, a0);
    send_byte(8'h0F, a1);
    send_byte(8'h11, a2);
    send_byte(8'h22, a3);
    i2c_stop;
    repeat (10) @(negedge clk);
    checks++; if ({a0, a1, a2, a3} !== 4'b0000) begin errors++;
      $display("FAIL wrap_acks: got %b expected 0000", {a0, a1, a2, a3}); end
    checks++; if (strobe_cnt - base !== 2) begin errors++;
      $display("FAIL wrap_strobes: got %0d expected 2", strobe_cnt - base); end
    checks++; if (last_addr !== 8'h00 || last_data !== 8'h22) begin errors++;
      $display("FAIL wrap_commit: got %h/%h expected 00/22", last_addr, last_data); end
    i2c_start;
    send_byte(8'h34, a4);
    send_byte(8'h0F, a5);
    i2c_start;
    send_byte(8'h35, a6);
    recv_byte(1'b0, d0);
    recv_byte(1'b1, d1);
    i2c_stop;
    repeat (10) @(negedge clk);
    checks++; if (d0 !== 8'h11 || d1 !== 8'h22) begin errors++;
      $display("FAIL wrap_read: got %h %h expected 11 22", d0, d1); end
  endtask

  task automatic test_bad_ptr;
    logic a0, a1;
    int base;
    base = strobe_cnt;
    i2c_start;
    send_byte(8'h34, a0);
    send_byte(8'h10, a1);
    i2c_stop;
    repeat (10) @(negedge clk);
    checks++; if ({a0, a1} !== 2'b01) begin errors++;
      $display("FAIL badptr_acks: got %b expected 01", {a0, a1}); end
    checks++; if (strobe_cnt - base !== 0) begin errors++;
      $display("FAIL badptr_strobes: got %0d expected 0", strobe_cnt - base); end
  endtask

  task automatic test_abort_reset;
    logic a0, a1;
    logic [7:0] b;
    int base;
    int n;
    base = strobe_cnt;
    i2c_start;
    send_byte(8'h34, a0);
    send_byte(8'h02, a1);
    wr_bit(1'b1); wr_bit(1'b1); wr_bit(1'b0); wr_bit(1'b1);
    i2c_stop;
    repeat (10) @(negedge clk);
    checks++; if (strobe_cnt - base !== 0) begin errors++;
      $display("FAIL abort_strobes: got %0d expected 0", strobe_cnt - base); end
    checks++; if (dut.regs_q[2] !== 8'h00) begin errors++;
      $display("FAIL abort_reg2: got %h expected 00", dut.regs_q[2]); end
    i2c_start;
    b = 8'h34;
    for (int i = 7; i >= 0; i--) wr_bit(b[i]);
    n = 0;
    while (i2c_sda_t !== 1'b0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    checks++; if (i2c_sda_t !== 1'b0) begin errors++;
      $display("FAIL abort_ack_drive: got %b expected 0", i2c_sda_t); end
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    checks++; if (i2c_sda_t !== 1'b1) begin errors++;
      $display("FAIL abort_async_rel: got %b expected 1", i2c_sda_t); end
    m_scl = 1'b1;
    m_sda = 1'b1;
    repeat (5) @(negedge clk);
    reset = 1'b0;
    repeat (10) @(negedge clk);
    checks++; if (dut.state_q !== IDLE || bus_active !== 1'b0) begin errors++;
      $display("FAIL abort_post: got %0d/%b expected IDLE/0", dut.state_q, bus_active); end
  endtask

  initial begin
    test_reset;
    test_write;
    test_write_reg4;
    test_read;
    test_nomatch;
    test_wrap;
    test_bad_ptr;
    test_abort_reset;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
